// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a small RV32 subset (R, I-ALU, LW, SW, BEQ).
// Build option: define ILLEGAL_TRAP_EN to trap on unsupported opcodes; otherwise they retire as NOPs.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ImmSel,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        pc_en,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal_instr
);

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    DECODE  = 3'b001,
    EXECUTE = 3'b010,
    MEM     = 3'b011,
    WB      = 3'b100,
    TRAP    = 3'b101
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     cur;
  logic [6:0] ir_op;
  logic [2:0] ir_f3;
  logic       ir_f7;

  logic       is_r, is_i, is_load, is_store, is_branch, is_legal;
  logic       alt_op;
  logic [3:0] alu_code;
  logic [1:0] imm_code;

  // The branch outcome is resolved by the datapath; zero and the register/immediate fields never reach the sequencer.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, zero, instruction[31], instruction[29:15], instruction[11:7]};

  assign is_r      = (ir_op == OP_R);
  assign is_i      = (ir_op == OP_I);
  assign is_load   = (ir_op == OP_LOAD);
  assign is_store  = (ir_op == OP_STORE);
  assign is_branch = (ir_op == OP_BRANCH);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

  // funct7[5] selects SUB/SRA for R-type, but only SRAI among the immediate forms.
  assign alt_op = ir_f7 & (is_r | (ir_f3 == 3'b101));

  always_comb begin
    alu_code = 4'b0000;
    if (is_branch) begin
      alu_code = 4'b0001;
    end else if (is_r | is_i) begin
      case (ir_f3)
        3'b000:  alu_code = alt_op ? 4'b0001 : 4'b0000;
        3'b001:  alu_code = 4'b0101;
        3'b010:  alu_code = 4'b1000;
        3'b011:  alu_code = 4'b1001;
        3'b100:  alu_code = 4'b0100;
        3'b101:  alu_code = alt_op ? 4'b0111 : 4'b0110;
        3'b110:  alu_code = 4'b0011;
        default: alu_code = 4'b0010;
      endcase
    end
  end

  always_comb begin
    imm_code = 2'b00;
    if (is_store)  imm_code = 2'b01;
    if (is_branch) imm_code = 2'b10;
  end

  // Controls are decoded from the registered state and IR, so reset clears them without waiting for an edge.
  always_comb begin
    ImmSel     = 2'b00;
    ALUControl = 4'b0000;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 1'b0;
    pc_en      = 1'b0;
    if (cur == EXECUTE || cur == MEM || cur == WB) begin
      ImmSel     = imm_code;
      ALUControl = alu_code;
      ALUSrc     = is_i | is_load | is_store;
    end
    case (cur)
      EXECUTE: begin
        PCSrc = is_branch;
`ifdef ILLEGAL_TRAP_EN
        pc_en = is_branch;
`else
        pc_en = is_branch | ~is_legal;
`endif
      end
      MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
        pc_en    = is_store & mem_ready;
      end
      WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_load;
        pc_en    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      ir_op   <= 7'd0;
      ir_f3   <= 3'd0;
      ir_f7   <= 1'b0;
      retired <= 32'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      retired <= retired + 32'(pc_en);
      case (cur)
        FETCH: cur <= DECODE;
        DECODE: begin
          ir_op <= instruction[6:0];
          ir_f3 <= instruction[14:12];
          ir_f7 <= instruction[30];
          cur   <= EXECUTE;
        end
        EXECUTE: begin
          if (is_r | is_i)             cur <= WB;
          else if (is_load | is_store) cur <= MEM;
          else if (is_branch)          cur <= FETCH;
          else begin
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b1;
            cur       <= TRAP;
`else
            cur <= FETCH;
`endif
          end
        end
        MEM: begin
          if (mem_ready) cur <= is_load ? WB : FETCH;
        end
        WB:      cur <= FETCH;
        TRAP:    cur <= TRAP;
        default: cur <= FETCH;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: a per-instruction phase model derived from the
// instruction class predicts every cycle's strobes, latency and the retired count.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ImmSel;
  logic [3:0]  ALUControl;
  logic        RegWrite, MemWrite, MemRead, ALUSrc, MemtoReg, PCSrc, pc_en;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        illegal_instr;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .ImmSel(ImmSel), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .pc_en(pc_en),
    .state(state), .retired(retired), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired;
  logic        exp_illegal;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Move to the next sampling point: inputs change on the falling edge, outputs are read 1ns later.
  task automatic advance(input logic mr);
    @(negedge clk);
    mem_ready = mr;
    zero      = 1'($urandom_range(0, 1));
    #1;
  endtask

  // 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 unsupported
  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input int kind, input logic [2:0] f3, input logic b30);
    logic [3:0] by_f3 [8];
    by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (kind == 2 || kind == 3) return 4'd0;
    if (kind == 4) return 4'd1;
    if (kind == 5) return 4'd0;
    if (f3 == 3'd0 && kind == 0 && b30) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd7;
    return by_f3[f3];
  endfunction

  // Walk one instruction from its FETCH cycle to the next instruction's FETCH cycle.
  // waits < 0 draws random memory wait states; otherwise exactly that many.
  task automatic run_instr(input logic [31:0] instr, input int waits);
    int         kind, phase, cycles, mem_cycles, trap_cycles, exp_lat;
    logic [3:0] alu;
    logic [1:0] imm;
    logic       src, done, exp_pcen, nmr;
    logic [6:0] op;
    op          = instr[6:0];
    kind        = kind_of(op);
    alu         = ref_alu(kind, instr[14:12], instr[30]);
    imm         = (kind == 3) ? 2'b01 : (kind == 4) ? 2'b10 : 2'b00;
    src         = (kind == 1 || kind == 2 || kind == 3);
    instruction = instr;
    phase       = 0;
    cycles      = 0;
    mem_cycles  = 0;
    trap_cycles = 0;
    done        = 1'b0;
    while (!done && cycles < 40) begin
      cycles++;
      exp_pcen = (phase == 2 && (kind == 4 || (kind == 5 && !TRAP_EN))) ||
                 (phase == 3 && kind == 3 && mem_ready) || (phase == 4);
      check("state", 32'(state), 32'(phase));
      check("retired", retired, exp_retired);
      check("illegal_instr", 32'(illegal_instr), 32'(exp_illegal));
      check("pc_en", 32'(pc_en), 32'(exp_pcen));
      check("RegWrite", 32'(RegWrite), 32'(phase == 4));
      check("MemRead", 32'(MemRead), 32'(phase == 3 && kind == 2));
      check("MemWrite", 32'(MemWrite), 32'(phase == 3 && kind == 3));
      if (phase >= 2 && phase <= 4 && kind != 5) begin
        check("ALUControl", 32'(ALUControl), 32'(alu));
        check("ImmSel", 32'(ImmSel), 32'(imm));
        check("ALUSrc", 32'(ALUSrc), 32'(src));
      end
      if (phase == 2) check("PCSrc", 32'(PCSrc), 32'(kind == 4));
      if (phase == 4) check("MemtoReg", 32'(MemtoReg), 32'(kind == 2));
      if (exp_pcen) exp_retired++;
      case (phase)
        0: phase = 1;
        1: phase = 2;
        2: begin
          if (kind <= 1) phase = 4;
          else if (kind <= 3) phase = 3;
          else if (kind == 5 && TRAP_EN) begin
            phase       = 5;
            exp_illegal = 1'b1;
          end else done = 1'b1;
        end
        3: begin
          mem_cycles++;
          if (mem_ready) begin
            if (kind == 2) phase = 4;
            else done = 1'b1;
          end
        end
        4: done = 1'b1;
        default: begin
          trap_cycles++;
          if (trap_cycles == 3) done = 1'b1;
        end
      endcase
      if (!done && phase == 3) begin
        if (waits >= 0) nmr = (mem_cycles >= waits);
        else nmr = (mem_cycles >= 4) || ($urandom_range(0, 2) == 0);
      end else begin
        nmr = 1'($urandom_range(0, 1));
      end
      advance(nmr);
    end
    check("completed", 32'(done), 32'd1);
    if (phase != 5) begin
      case (kind)
        0, 1:    exp_lat = 4;
        2:       exp_lat = 5 + ((waits >= 0) ? waits : mem_cycles - 1);
        3:       exp_lat = 4 + ((waits >= 0) ? waits : mem_cycles - 1);
        default: exp_lat = 3;
      endcase
      check("latency", 32'(cycles), 32'(exp_lat));
    end
  endtask

  function automatic logic [31:0] random_instr(input int kind);
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case (kind)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (kind_of(op) != 5) op = 7'($urandom_range(0, 127));
      end
    endcase
    w[6:0] = op;
    return w;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog no progress at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instruction = 32'd0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    exp_retired = 32'd0;
    exp_illegal = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    run_instr(32'h002081B3, -1);  // ADD x3,x1,x2
    run_instr(32'h0000A103, 3);   // LW with three wait states
    run_instr(32'h0020A023, 0);   // SW completing immediately
    run_instr(32'h00208463, -1);  // BEQ
    run_instr(32'h00208463, -1);
    run_instr(32'h40208033, -1);  // SUB
    run_instr(32'h4030D093, -1);  // SRAI
    run_instr(32'h40308093, -1);  // ADDI with bit 30 set, still ADD

    for (int n = 0; n < 60; n++) begin
      int k;
      k = TRAP_EN ? $urandom_range(0, 4) : $urandom_range(0, 5);
      run_instr(random_instr(k), -1);
    end

    // Reset while a load is stalled in MEM.
    instruction = 32'h0000A103;
    advance(1'b0);
    advance(1'b0);
    advance(1'b0);
    check("mid_mem_state", 32'(state), 32'd3);
    check("mid_mem_read", 32'(MemRead), 32'd1);
    advance(1'b0);
    check("mid_mem_hold", 32'(state), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_memread", 32'(MemRead), 32'd0);
    check("async_retired", retired, 32'd0);
    check("async_alusrc", 32'(ALUSrc), 32'd0);
    check("async_illegal", 32'(illegal_instr), 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    exp_retired = 32'd0;
    exp_illegal = 1'b0;
    #1;
    run_instr(32'h002081B3, -1);
    run_instr(32'h0000A103, 1);

    run_instr(32'h0000007F, -1);  // unsupported opcode
    check("final_retired", retired, exp_retired);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
